// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_pkg : one-hot FSM states, command codes, counter width helper  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package spi_slave_pkg;

    localparam logic [4:0] ST_IDLE_OH      = 5'b00001;
    localparam logic [4:0] ST_CHK_CMD_OH   = 5'b00010;
    localparam logic [4:0] ST_WRITE_OH     = 5'b00100;
    localparam logic [4:0] ST_READ_ADD_OH  = 5'b01000;
    localparam logic [4:0] ST_READ_DATA_OH = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE      = ST_IDLE_OH,
        ST_CHK_CMD   = ST_CHK_CMD_OH,
        ST_WRITE     = ST_WRITE_OH,
        ST_READ_ADD  = ST_READ_ADD_OH,
        ST_READ_DATA = ST_READ_DATA_OH
    } spi_state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Counter must reach DATA_W+2 without wrapping.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_piso_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_piso_shift : load/shift PISO driving registered MISO, MSB first      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module spi_piso_shift #(
    parameter int   DATA_W    = 8,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              busy
);

    localparam int LW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sreg;
    logic [LW-1:0]     left;

    // The MSB goes straight to MISO on load; sreg holds the remaining bits.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            miso <= MISO_IDLE;
            busy <= 1'b0;
            left <= '0;
            sreg <= '0;
        end else if (load && !busy) begin
            miso <= data[DATA_W-1];
            sreg <= data << 1;
            left <= LW'(DATA_W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (left != '0) begin
                miso <= sreg[DATA_W-1];
                sreg <= sreg << 1;
                left <= left - 1'b1;
            end else begin
                miso <= MISO_IDLE;
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_param : SPI slave front-end, DATA_W+2 bit rx words, tx on MISO |
// | Option: SPI_SLAVE_FRAME_ERR_EN adds frame_err abort pulse  Revision: 1.0 |
// +--------------------------------------------------------------------------+
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int             CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_W + 2);

    spi_state_t      state;
    logic [DATA_W:0] shift;
    logic [CW-1:0]   cnt;
    logic            rd_addr_seen;
    logic            tx_loaded;
    logic            piso_busy;
    logic            in_word;
    logic            tx_load;

    assign in_word = (state == ST_WRITE) || (state == ST_READ_ADD) || (state == ST_READ_DATA);
    // Single tx window: READ_DATA word done, nothing loaded yet this frame.
    assign tx_load = (state == ST_READ_DATA) && !SS_n && (cnt == CNT_FULL)
                     && !tx_loaded && !piso_busy && tx_valid;

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        if (rst) begin
            state        <= ST_IDLE;
            shift        <= '0;
            cnt          <= '0;
            rx_data      <= '0;
            rd_addr_seen <= 1'b0;
            tx_loaded    <= 1'b0;
        end else if (SS_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tx_loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_CHK_CMD;
                    shift     <= '0;
                    cnt       <= '0;
                    tx_loaded <= 1'b0;
                end
                ST_CHK_CMD: begin
                    state <= MOSI ? (rd_addr_seen ? ST_READ_DATA : ST_READ_ADD) : ST_WRITE;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt != CNT_FULL) begin
                        shift <= {shift[DATA_W-1:0], MOSI};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_FULL - 1'b1) begin
                            rx_data  <= {shift, MOSI};
                            rx_valid <= 1'b1;
                            if (state == ST_READ_ADD)  rd_addr_seen <= 1'b1;
                            if (state == ST_READ_DATA) rd_addr_seen <= 1'b0;
                        end
                    end
                    if (tx_load) tx_loaded <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= SS_n && ((in_word && cnt != '0 && cnt != CNT_FULL) || piso_busy);
        end
    end
`endif

    spi_piso_shift #(
        .DATA_W    (DATA_W),
        .MISO_IDLE (MISO_IDLE)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .abort (SS_n),
        .load  (tx_load),
        .data  (tx_data),
        .miso  (MISO),
        .busy  (piso_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_slave_param : directed table + sequence bench for spi_slave_param |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_spi_slave_param;

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_WR   = 5'b00100;
    localparam logic [4:0] S_RA   = 5'b01000;
    localparam logic [4:0] S_RD   = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data8 = '0;
    logic [15:0] tx_data16 = '0;
    logic        miso8, miso16;
    logic [9:0]  rx_data8;
    logic [17:0] rx_data16;
    logic        rx_valid8, rx_valid16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err8, frame_err16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .MISO_IDLE(1'b0)) dut8 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_data(tx_data8), .tx_valid(tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err8)
`endif
    );

    spi_slave_param #(.DATA_W(16), .MISO_IDLE(1'b1)) dut16 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err16)
`endif
    );

    typedef struct {
        logic       cmd;
        logic [9:0] word;
        logic [4:0] exp_state;
        logic       exp_seen;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full 8-bit frame: select cycle, command bit, 10 word bits, 3 ignored bits; SS_n stays low.
    task automatic frame8(input logic cmd, input logic [9:0] w, input logic [4:0] st,
                          input logic seen, input string tag);
        logic [9:0] held;
        SS_n = 1'b0; MOSI = 1'b0; tick();
        MOSI = cmd; tick();
        check({tag, " state"}, 32'(dut8.state), 32'(st));
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            tick();
            if (i == 1) check({tag, " no early valid"}, 32'(rx_valid8), 32'd0);
        end
        check({tag, " rx_valid"}, 32'(rx_valid8), 32'd1);
        check({tag, " rx_data"}, 32'(rx_data8), 32'(w));
        check({tag, " rd_addr_seen"}, 32'(dut8.rd_addr_seen), 32'(seen));
        held = w;
        MOSI = ~w[0]; tick();
        check({tag, " pulse one cycle"}, 32'(rx_valid8), 32'd0);
        MOSI = 1'b1; tick();
        MOSI = 1'b0; tick();
        check({tag, " extra bits ignored"}, 32'({rx_valid8, rx_data8}), 32'({1'b0, held}));
    endtask

    task automatic end_frame(input string tag);
        SS_n = 1'b1; MOSI = 1'b0; tick();
        check({tag, " idle after SS_n"}, 32'(dut8.state), 32'(S_IDLE));
        tick();
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] txw;
        logic [17:0] w16;

        vecs[0] = '{1'b0, 10'h0A5, S_WR, 1'b0};
        vecs[1] = '{1'b1, 10'h203, S_RA, 1'b1};
        vecs[2] = '{1'b1, 10'h3FF, S_RD, 1'b0};
        vecs[3] = '{1'b0, 10'h15A, S_WR, 1'b0};
        vecs[4] = '{1'b1, 10'h2AA, S_RA, 1'b1};
        vecs[5] = '{1'b0, 10'h100, S_WR, 1'b1};
        vecs[6] = '{1'b1, 10'h355, S_RD, 1'b0};

        tick(); tick();
        rst = 1'b0;
        check("reset state", 32'(dut8.state), 32'(S_IDLE));
        check("reset rx_data", 32'(rx_data8), 32'd0);
        check("reset rx_valid", 32'(rx_valid8), 32'd0);
        check("reset MISO", 32'(miso8), 32'd0);
        check("reset rd_addr_seen", 32'(dut8.rd_addr_seen), 32'd0);
        check("reset MISO idle=1", 32'(miso16), 32'd1);

        for (int i = 0; i < 7; i++) begin
            frame8(vecs[i].cmd, vecs[i].word, vecs[i].exp_state, vecs[i].exp_seen,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d MISO idle", i), 32'(miso8), 32'd0);
            end_frame($sformatf("vec%0d", i));
        end

        // Read address then read data with tx return; late tx_valid pulses ignored.
        frame8(1'b1, 10'h203, S_RA, 1'b1, "rdaddr");
        end_frame("rdaddr");
        frame8(1'b1, 10'h3C0, S_RD, 1'b0, "rddata");
        txw = 8'hC3;
        tx_data8 = txw; tx_valid = 1'b1; tick();
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("tx bit%0d", i), 32'(miso8), 32'(txw[i]));
            tx_valid = (i == 5);
            tx_data8 = (i == 5) ? 8'h00 : txw;
            tick();
        end
        check("tx back to idle", 32'(miso8), 32'd0);
        tx_data8 = 8'hFF; tx_valid = 1'b1; tick();
        tx_valid = 1'b0; tick();
        check("tx no reload", 32'(miso8), 32'd0);
        end_frame("rddata");

        // Abort a write after 5 of 10 bits.
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin MOSI = i[0]; tick(); end
        SS_n = 1'b1; tick();
        check("abort wr state", 32'(dut8.state), 32'(S_IDLE));
        check("abort wr rx_valid", 32'(rx_valid8), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort wr frame_err", 32'(frame_err8), 32'd1);
`endif
        tick();
        check("abort wr rx_valid later", 32'(rx_valid8), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort wr frame_err pulse", 32'(frame_err8), 32'd0);
`endif

        // Abort during tx shifting.
        frame8(1'b1, 10'h2F0, S_RA, 1'b1, "ab_ra");
        end_frame("ab_ra");
        frame8(1'b1, 10'h3AB, S_RD, 1'b0, "ab_rd");
        tx_data8 = 8'hFF; tx_valid = 1'b1; tick();
        tx_valid = 1'b0; tick(); tick();
        check("abort tx shifting", 32'(miso8), 32'd1);
        SS_n = 1'b1; tick();
        check("abort tx MISO idle", 32'(miso8), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort tx frame_err", 32'(frame_err8), 32'd1);
`endif
        tick();

        // Reset in the middle of a tx shift, then a clean frame.
        frame8(1'b1, 10'h211, S_RA, 1'b1, "rs_ra");
        end_frame("rs_ra");
        frame8(1'b1, 10'h300, S_RD, 1'b0, "rs_rd");
        tx_data8 = 8'hFF; tx_valid = 1'b1; tick();
        tx_valid = 1'b0; tick();
        rst = 1'b1; tick();
        check("rst MISO", 32'(miso8), 32'd0);
        check("rst rx_valid", 32'(rx_valid8), 32'd0);
        check("rst state", 32'(dut8.state), 32'(S_IDLE));
        rst = 1'b0; SS_n = 1'b1; tick();
        frame8(1'b1, 10'h2F0, S_RA, 1'b1, "post_rst");
        end_frame("post_rst");
        rst = 1'b1; tick();
        check("rst clears rd_addr_seen", 32'(dut8.rd_addr_seen), 32'd0);
        rst = 1'b0; tick();
        frame8(1'b1, 10'h201, S_RA, 1'b1, "post_rst2");
        end_frame("post_rst2");

        // DATA_W=16 write of 18'h2BEEF with trailing bits.
        w16 = 18'h2BEEF;
        SS_n = 1'b0; MOSI = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 17; i >= 0; i--) begin MOSI = w16[i]; tick(); end
        check("w16 rx_valid", 32'(rx_valid16), 32'd1);
        check("w16 rx_data", 32'(rx_data16), 32'(w16));
        for (int i = 0; i < 4; i++) begin MOSI = 1'b1; tick(); end
        check("w16 extra ignored", 32'({rx_valid16, rx_data16}), 32'({1'b0, w16}));
        check("w16 MISO idle", 32'(miso16), 32'd1);
        SS_n = 1'b1; tick(); tick();

        // tx_valid outside the wait window.
        tx_data8 = 8'hFF; tx_valid = 1'b1; tick();
        check("txv idle MISO", 32'(miso8), 32'd0);
        check("txv idle state", 32'(dut8.state), 32'(S_IDLE));
        tx_valid = 1'b0;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        tx_valid = 1'b1; tick(); tick();
        check("txv write MISO", 32'(miso8), 32'd0);
        check("txv write state", 32'(dut8.state), 32'(S_WR));
        tx_valid = 1'b0;
        SS_n = 1'b1; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
